// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
//   Definitions shared by the APB master bridge and its wait-state timer:
//   the bridge state encoding and the default ACCESS-phase timeout.
// -----------------------------------------------------------------------------
package apb_pkg;

  // Bridge phases: accept a request, drive the APB SETUP and ACCESS phases,
  // then hold the response until the consumer takes it.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Maximum number of ACCESS cycles with PREADY=0 before the transfer is
  // abandoned. The legal range is 1..65535.
  localparam int APB_TIMEOUT_DEFAULT = 256;

endpackage : apb_pkg

// File: rtl/apb_timeout_timer.sv
// -----------------------------------------------------------------------------
// apb_timeout_timer
//   Counts ACCESS-phase wait states and flags the wait cycle on which the
//   count reaches LIMIT.
//
//   Ports
//     PCLK      in   clock, rising edge
//     PRESETn   in   asynchronous active-low reset
//     i_clear   in   zero the counter (asserted in the cycle before ACCESS)
//     i_enable  in   count this cycle (ACCESS with PREADY=0)
//     o_expired out  this enabled cycle brings the count up to LIMIT
// -----------------------------------------------------------------------------
module apb_timeout_timer #(
  parameter int LIMIT = apb_pkg::APB_TIMEOUT_DEFAULT
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(LIMIT - 1);
  localparam logic [CW-1:0] MAX_COUNT = CW'(LIMIT);

  logic [CW-1:0] r_count;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; a blocking = here would create ordering-dependent
  // behaviour between always_ff blocks.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != MAX_COUNT)) begin
      // Saturates at LIMIT so the count can never wrap back to zero.
      r_count <= r_count + 1'b1;
    end
  end

  // Flagged combinationally so the bridge leaves ACCESS right after the
  // LIMIT-th wait cycle rather than one cycle later.
  assign o_expired = i_enable && (r_count == LAST_WAIT);

endmodule : apb_timeout_timer

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//   Converts a valid/ready request into a single APB transfer and returns the
//   outcome on a valid/ready response channel. A stalled ACCESS phase is
//   abandoned after TIMEOUT_CYCLES wait states and reported as an error.
//
//   Ports
//     PCLK, PRESETn                 clock / asynchronous active-low reset
//     req_valid/req_ready           request handshake (ready only in IDLE)
//     req_write/req_addr/req_wdata  request payload
//     rsp_valid/rsp_ready           response handshake
//     rsp_rdata/rsp_err             read data (0 for writes/aborts), error
//     PADDR/PSEL/PENABLE/PWRITE/PWDATA  APB master outputs
//     PRDATA/PREADY/PSLVERR         APB slave inputs
// -----------------------------------------------------------------------------
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_state_e r_state;
  apb_state_e w_state_next;

  logic                  w_timer_clear;
  logic                  w_timer_en;
  logic                  w_expired;
  logic                  w_req_fire;

  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  assign w_req_fire = req_valid && (r_state == ST_IDLE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and timer control
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_timer_clear = 1'b0;
    w_timer_en    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) w_state_next = ST_SETUP;
      end
      ST_SETUP: begin
        // Zero the wait counter as ACCESS is entered.
        w_timer_clear = 1'b1;
        w_state_next  = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_timer_en = !PREADY;
        // PREADY is tested first so a completion on the limit cycle wins
        // over the timeout.
        if (PREADY || w_expired) w_state_next = ST_RESP;
      end
      ST_RESP: begin
        // Returning to IDLE (not straight to SETUP) guarantees an idle cycle
        // between transfers.
        if (rsp_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  apb_timeout_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_en),
    .o_expired (w_expired)
  );

  // ---------------------------------------------------------------------------
  // Request capture and response latch
  // ---------------------------------------------------------------------------
  // NOTE: these are plain registers (not a memory), so all of them are reset;
  // that is what makes the APB and response outputs drop to zero the moment
  // PRESETn falls.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      // Captured only at the request handshake, so the APB payload is stable
      // through SETUP/ACCESS and keeps its last value afterwards.
      if (w_req_fire) begin
        r_paddr  <= req_addr;
        r_pwrite <= req_write;
        r_pwdata <= req_wdata;
      end
      // The slave's PRDATA/PSLVERR only matter on a completing ACCESS cycle.
      if (r_state == ST_ACCESS) begin
        if (PREADY) begin
          r_rsp_err   <= PSLVERR;
          r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
        end else if (w_expired) begin
          r_rsp_err   <= 1'b1;
          r_rsp_rdata <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from the state register, so reset clears them at once)
  // ---------------------------------------------------------------------------
  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign PSEL      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign PENABLE   = (r_state == ST_ACCESS);
  assign PADDR     = r_paddr;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule : apb_master_bridge

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//   Directed bench for apb_master_bridge with TIMEOUT_CYCLES = 8. The APB slave
//   is driven cycle by cycle from the stimulus; expected values are written
//   out by hand next to each comparison.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          PCLK;
  logic          PRESETn;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int n_checks = 0;
  int n_errors = 0;

  apb_master_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Offer one request in IDLE; returns positioned in the SETUP cycle.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    check("idle_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("setup_psel",    PSEL,    1);
    check("setup_penable", PENABLE, 0);
    check("setup_paddr",   PADDR,   a);
    check("setup_pwrite",  PWRITE,  w);
  endtask

  // Consume the response shown in RESP; returns positioned in IDLE.
  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("after_rsp_valid", rsp_valid, 0);
    check("after_rsp_ready", req_ready, 1);
  endtask

  initial begin
    PRESETn   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    // ---------------- Reset values ----------------
    repeat (2) @(posedge PCLK);
    #1;
    check("rst_psel",      PSEL,      0);
    check("rst_penable",   PENABLE,   0);
    check("rst_paddr",     PADDR,     0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    tick();

    // ---------------- Zero-wait write ----------------
    PREADY = 1'b1;
    issue(1'b1, 32'h1000_0080, 32'h0000_0055);          // cycle 1
    check("wr_pwdata", PWDATA, 32'h55);
    tick();                                              // cycle 2
    check("wr_access_psel",    PSEL,    1);
    check("wr_access_penable", PENABLE, 1);
    tick();                                              // cycle 3
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_err",   rsp_err,   0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_rsp_psel",  PSEL,      0);
    take_rsp();

    // ---------------- Read with 3 wait states ----------------
    // PSLVERR and junk PRDATA during wait cycles must be ignored.
    PREADY  = 1'b0;
    PSLVERR = 1'b1;
    PRDATA  = 32'hDEAD_BEEF;
    issue(1'b0, 32'h1000_0040, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("rd3_access_penable", PENABLE, 1);
      check("rd3_access_paddr",   PADDR,   32'h1000_0040);
      if (i == 3) begin
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = 32'h0001_0100;
      end
      tick();
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b1;
    PRDATA  = 32'h7777_7777;
    check("rd3_rsp_valid", rsp_valid, 1);
    check("rd3_rsp_rdata", rsp_rdata, 32'h0001_0100);
    check("rd3_rsp_err",   rsp_err,   0);
    check("rd3_rsp_paddr", PADDR,     32'h1000_0040);

    // ---------------- Response back-pressure ----------------
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0020;
    req_wdata = 32'h0000_00AB;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 32'h0001_0100);
      check("bp_rsp_err",   rsp_err,   0);
      check("bp_req_ready", req_ready, 0);
      check("bp_psel",      PSEL,      0);
      tick();
    end
    rsp_ready = 1'b1;                                    // response handshake
    tick();
    rsp_ready = 1'b0;
    check("bp_idle_req_ready", req_ready, 1);
    check("bp_idle_psel",      PSEL,      0);
    check("bp_idle_rsp_valid", rsp_valid, 0);
    tick();                                              // 2 cycles after rsp hs
    req_valid = 1'b0;
    check("bp_setup_psel",  PSEL,  1);
    check("bp_setup_paddr", PADDR, 32'h20);
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    tick();
    check("bp_access_penable", PENABLE, 1);
    tick();
    check("bp_wr_rsp_valid", rsp_valid, 1);
    check("bp_wr_rsp_rdata", rsp_rdata, 0);
    take_rsp();

    // ---------------- PSLVERR on a read ----------------
    PREADY  = 1'b1;
    PSLVERR = 1'b1;
    PRDATA  = 32'hCAFE_F00D;
    issue(1'b0, 32'h0000_0400, 32'h0);
    tick();
    PSLVERR = 1'b0;                                      // sampled already? no: sampled at next edge
    PSLVERR = 1'b1;
    tick();
    PSLVERR = 1'b0;
    check("slverr_rsp_valid", rsp_valid, 1);
    check("slverr_rsp_err",   rsp_err,   1);
    check("slverr_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
    take_rsp();

    // ---------------- Timeout: slave never ready ----------------
    PREADY = 1'b0;
    PRDATA = 32'hFFFF_FFFF;
    issue(1'b0, 32'h0000_0300, 32'h0);
    tick();
    for (int i = 0; i < TO; i++) begin
      check("to_access_psel",    PSEL,    1);
      check("to_access_penable", PENABLE, 1);
      tick();
    end
    check("to_psel_dropped", PSEL,      0);
    check("to_rsp_valid",    rsp_valid, 1);
    check("to_rsp_err",      rsp_err,   1);
    check("to_rsp_rdata",    rsp_rdata, 0);
    take_rsp();

    // ---------------- PREADY on the limit cycle completes normally ----------
    PREADY = 1'b0;
    issue(1'b0, 32'h0000_0500, 32'h0);
    tick();
    for (int i = 0; i < TO; i++) begin
      check("lim_access_penable", PENABLE, 1);
      if (i == TO - 1) begin
        PREADY = 1'b1;
        PRDATA = 32'h1234_5678;
      end
      tick();
    end
    PREADY = 1'b0;
    check("lim_rsp_valid", rsp_valid, 1);
    check("lim_rsp_err",   rsp_err,   0);
    check("lim_rsp_rdata", rsp_rdata, 32'h1234_5678);
    take_rsp();

    // ---------------- Reset during ACCESS ----------------
    PREADY = 1'b0;
    issue(1'b1, 32'h0000_0600, 32'h0000_0077);
    tick();
    check("rstacc_penable", PENABLE, 1);
    #2;
    PRESETn = 1'b0;
    #1;
    check("rstacc_psel",      PSEL,      0);
    check("rstacc_penable0",  PENABLE,   0);
    check("rstacc_paddr",     PADDR,     0);
    check("rstacc_pwrite",    PWRITE,    0);
    check("rstacc_pwdata",    PWDATA,    0);
    check("rstacc_rsp_valid", rsp_valid, 0);
    check("rstacc_rsp_err",   rsp_err,   0);
    check("rstacc_rsp_rdata", rsp_rdata, 0);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    PREADY  = 1'b1;
    tick();
    check("rstrel_req_ready", req_ready, 1);
    check("rstrel_rsp_valid", rsp_valid, 0);
    check("rstrel_psel",      PSEL,      0);

    // Bridge recovers with a normal read.
    PRDATA = 32'h0BAD_CAFE;
    issue(1'b0, 32'h0000_0700, 32'h0);
    tick();
    tick();
    check("rec_rsp_valid", rsp_valid, 1);
    check("rec_rsp_rdata", rsp_rdata, 32'h0BAD_CAFE);
    take_rsp();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_apb_master_bridge
